// File: rtl/traffic_phase_ctrl_if.sv
// rtl/traffic_phase_ctrl_if.sv - phase-timer link between the sequencer and the loadable timer
interface traffic_phase_ctrl_if #(
  parameter int W = 6
);
  logic [W-1:0] count;
  logic         load;
  logic [W-1:0] value;

  modport master (input count, output load, output value);
  modport slave  (output count, input load, input value);
endinterface

// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - light-phase sequencer with latched WALK and flashing-yellow override
module traffic_phase_ctrl #(
  parameter int W        = 6,
  parameter int GREEN_T  = 30,
  parameter int YELLOW_T = 5,
  parameter int ALLRED_T = 2,
  parameter int WALK_T   = 10,
  parameter int FLASH_T  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  traffic_phase_ctrl_if.master tmr,
  input  logic                 ped_req_i,
  input  logic                 flash_i,
  output logic [2:0]           ns_light_o,
  output logic [2:0]           ew_light_o,
  output logic                 walk_o,
  output logic                 ped_wait_o,
  output logic [2:0]           phase_o
);

  localparam int T_MAX = (1 << W) - 1;

  if (GREEN_T < 1 || GREEN_T > T_MAX || YELLOW_T < 1 || YELLOW_T > T_MAX ||
      ALLRED_T < 1 || ALLRED_T > T_MAX || WALK_T < 1 || WALK_T > T_MAX ||
      FLASH_T < 1 || FLASH_T > T_MAX) begin : g_param_err
    $error("traffic_phase_ctrl: every duration must lie in 1..2^W-1");
  end

  localparam logic [W-1:0] C_GREEN  = W'(GREEN_T - 1);
  localparam logic [W-1:0] C_YELLOW = W'(YELLOW_T - 1);
  localparam logic [W-1:0] C_ALLRED = W'(ALLRED_T - 1);
  localparam logic [W-1:0] C_WALK   = W'(WALK_T - 1);
  localparam logic [W-1:0] C_FLASH  = W'(FLASH_T - 1);

  typedef enum logic [2:0] {
    RED_A     = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    RED_B     = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    WALK      = 3'd6,
    FLASH     = 3'd7
  } state_t;

  state_t       r_state;
  logic         r_load;
  logic [2:0]   r_ns;
  logic [2:0]   r_ew;
  logic         r_walk;
  logic         r_ped_pend;
  logic         r_flash_tgl;

  state_t       w_state_nx;
  logic         w_load_nx;
  logic         w_tgl_nx;
  logic [2:0]   w_ns_nx;
  logic [2:0]   w_ew_nx;
  logic         w_ped_nx;
  logic [W-1:0] w_end_cnt;
  logic         w_end;

  always_comb begin
    w_end_cnt = C_FLASH;
    case (r_state)
      RED_A, RED_B:         w_end_cnt = C_ALLRED;
      NS_GREEN, EW_GREEN:   w_end_cnt = C_GREEN;
      NS_YELLOW, EW_YELLOW: w_end_cnt = C_YELLOW;
      WALK:                 w_end_cnt = C_WALK;
      default:              w_end_cnt = C_FLASH;
    endcase
  end

  // The count seen during the load cycle is stale, so it never ends a phase.
  assign w_end = !r_load && (tmr.count == w_end_cnt);

  always_comb begin
    w_state_nx = r_state;
    w_load_nx  = 1'b0;
    w_tgl_nx   = r_flash_tgl;
    if (flash_i && r_state != FLASH) begin
      w_state_nx = FLASH;
      w_load_nx  = 1'b1;
      w_tgl_nx   = 1'b1;
    end else begin
      case (r_state)
        RED_A:     if (w_end) begin w_state_nx = r_ped_pend ? WALK : NS_GREEN; w_load_nx = 1'b1; end
        NS_GREEN:  if (w_end) begin w_state_nx = NS_YELLOW; w_load_nx = 1'b1; end
        NS_YELLOW: if (w_end) begin w_state_nx = RED_B;     w_load_nx = 1'b1; end
        RED_B:     if (w_end) begin w_state_nx = EW_GREEN;  w_load_nx = 1'b1; end
        EW_GREEN:  if (w_end) begin w_state_nx = EW_YELLOW; w_load_nx = 1'b1; end
        EW_YELLOW: if (w_end) begin w_state_nx = RED_A;     w_load_nx = 1'b1; end
        WALK:      if (w_end) begin w_state_nx = NS_GREEN;  w_load_nx = 1'b1; end
        FLASH: begin
          if (!flash_i) begin
            w_state_nx = RED_A;
            w_load_nx  = 1'b1;
          end else if (w_end) begin
            w_tgl_nx  = ~r_flash_tgl;
            w_load_nx = 1'b1;
          end
        end
        default: begin
          w_state_nx = RED_A;
          w_load_nx  = 1'b1;
        end
      endcase
    end
  end

  // Lamps follow the next state so they change on the same edge as the phase.
  always_comb begin
    w_ns_nx = 3'b100;
    w_ew_nx = 3'b100;
    case (w_state_nx)
      NS_GREEN:  w_ns_nx = 3'b001;
      NS_YELLOW: w_ns_nx = 3'b010;
      EW_GREEN:  w_ew_nx = 3'b001;
      EW_YELLOW: w_ew_nx = 3'b010;
      FLASH: begin
        w_ns_nx = w_tgl_nx ? 3'b010 : 3'b000;
        w_ew_nx = w_tgl_nx ? 3'b010 : 3'b000;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_ped_nx = r_ped_pend;
    if (w_state_nx == WALK && r_state != WALK) w_ped_nx = 1'b0;
    else if (ped_req_i && r_state != WALK)     w_ped_nx = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RED_A;
      r_load      <= 1'b1;
      r_ns        <= 3'b100;
      r_ew        <= 3'b100;
      r_walk      <= 1'b0;
      r_ped_pend  <= 1'b0;
      r_flash_tgl <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_load      <= w_load_nx;
      r_ns        <= w_ns_nx;
      r_ew        <= w_ew_nx;
      r_walk      <= (w_state_nx == WALK);
      r_ped_pend  <= w_ped_nx;
      r_flash_tgl <= w_tgl_nx;
    end
  end

  assign tmr.load   = r_load;
  assign tmr.value  = '0;
  assign ns_light_o = r_ns;
  assign ew_light_o = r_ew;
  assign walk_o     = r_walk;
  assign ped_wait_o = r_ped_pend;
  assign phase_o    = r_state;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb/tb_traffic_phase_ctrl.sv - self-checking bench for traffic_phase_ctrl
module tb_traffic_phase_ctrl;
  localparam int W = 6, GREEN_T = 30, YELLOW_T = 5, ALLRED_T = 2, WALK_T = 10, FLASH_T = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ped_req = 1'b0;
  logic flash = 1'b0;
  always #5 clk = ~clk;

  traffic_phase_ctrl_if #(.W(W)) tif ();
  traffic_phase_ctrl_if #(.W(W)) tif2 ();

  logic [2:0] ns, ew, ph, ns2, ew2, ph2;
  logic       walk, pw, walk2, pw2;

  traffic_phase_ctrl #(.W(W), .GREEN_T(GREEN_T), .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T),
                       .WALK_T(WALK_T), .FLASH_T(FLASH_T)) dut (
    .clk(clk), .rst(rst), .tmr(tif.master), .ped_req_i(ped_req), .flash_i(flash),
    .ns_light_o(ns), .ew_light_o(ew), .walk_o(walk), .ped_wait_o(pw), .phase_o(ph));

  traffic_phase_ctrl #(.W(W), .GREEN_T(63), .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T),
                       .WALK_T(WALK_T), .FLASH_T(FLASH_T)) dut2 (
    .clk(clk), .rst(rst), .tmr(tif2.master), .ped_req_i(1'b0), .flash_i(1'b0),
    .ns_light_o(ns2), .ew_light_o(ew2), .walk_o(walk2), .ped_wait_o(pw2), .phase_o(ph2));

  // Behavioural loadable timers.
  always @(posedge clk) tif.count  <= tif.load  ? tif.value  : tif.count  + 1'b1;
  always @(posedge clk) tif2.count <= tif2.load ? tif2.value : tif2.count + 1'b1;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: phase number, cycles spent in it, flash half, pending request.
  typedef struct packed {
    logic [2:0] ph;
    logic [7:0] age;
    logic       tgl;
    logic       ped;
  } mstate_t;

  function automatic int dur(input logic [2:0] p);
    case (p)
      3'd0, 3'd3: return ALLRED_T;
      3'd1, 3'd4: return GREEN_T;
      3'd2, 3'd5: return YELLOW_T;
      3'd6:       return WALK_T;
      default:    return FLASH_T;
    endcase
  endfunction

  function automatic logic [2:0] succ(input logic [2:0] p, input logic pend);
    case (p)
      3'd0:    return pend ? 3'd6 : 3'd1;
      3'd5:    return 3'd0;
      3'd6:    return 3'd1;
      default: return p + 3'd1;
    endcase
  endfunction

  function automatic mstate_t model_step(input mstate_t s, input logic fl, input logic rq);
    mstate_t n = s;
    n.age = s.age + 8'd1;
    if (fl && s.ph != 3'd7) begin
      n.ph = 3'd7; n.age = 8'd0; n.tgl = 1'b1;
    end else if (s.ph == 3'd7) begin
      if (!fl) begin n.ph = 3'd0; n.age = 8'd0; end
      else if (int'(s.age) == FLASH_T) begin n.tgl = ~s.tgl; n.age = 8'd0; end
    end else if (int'(s.age) == dur(s.ph)) begin
      n.ph = succ(s.ph, s.ped); n.age = 8'd0;
    end
    if (n.ph == 3'd6 && s.ph != 3'd6) n.ped = 1'b0;
    else if (s.ph != 3'd6 && rq)      n.ped = 1'b1;
    return n;
  endfunction

  function automatic logic [2:0] lamp(input bit is_ns, input mstate_t s);
    if (s.ph == 3'd7) return s.tgl ? 3'b010 : 3'b000;
    if (is_ns && s.ph == 3'd1)  return 3'b001;
    if (is_ns && s.ph == 3'd2)  return 3'b010;
    if (!is_ns && s.ph == 3'd4) return 3'b001;
    if (!is_ns && s.ph == 3'd5) return 3'b010;
    return 3'b100;
  endfunction

  function automatic logic [31:0] exp_vec(input mstate_t s);
    return {14'd0, s.ph, (s.age == 8'd0), lamp(1'b1, s), lamp(1'b0, s), (s.ph == 3'd6), s.ped, 6'd0};
  endfunction

  mstate_t m;
  bit      cmp_en = 1'b0;

  always @(posedge clk or posedge rst)
    if (rst) m <= '0;
    else     m <= model_step(m, flash, ped_req);

  always @(negedge clk)
    if (cmp_en) check("model", {14'd0, ph, tif.load, ns, ew, walk, pw, tif.value}, exp_vec(m));

  int g2_run = 0;
  int g2_len = 0;
  always @(negedge clk)
    if (rst) g2_run <= 0;
    else if (ph2 == 3'd1) g2_run <= g2_run + 1;
    else if (g2_run != 0 && g2_len == 0) g2_len <= g2_run;

  task automatic run_len(input logic [2:0] p, output int len);
    len = 0;
    while (ph === p && len < 300) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic wait_phase(input logic [2:0] p);
    int n = 0;
    while (ph !== p && n < 300) begin
      n++;
      @(negedge clk);
    end
    check("wait_phase", {29'd0, ph}, {29'd0, p});
  endtask

  int len;
  int lens[6] = '{3, 31, 6, 3, 31, 6};

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;

    // Free-running cycle with no requests.
    for (int i = 0; i < 6; i++) begin
      logic [2:0] p;
      p = i[2:0];
      check("entry_load", {31'd0, tif.load}, 32'd1);
      run_len(p, len);
      check($sformatf("len_phase%0d", i), len, lens[i]);
    end
    check("back_to_red_a", {29'd0, ph}, 32'd0);
    run_len(3'd0, len);
    check("red_a_len", len, 3);
    check("red_a_to_green", {29'd0, ph}, 32'd1);

    // Pedestrian request in NS_GREEN.
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    check("ped_wait_set", {31'd0, pw}, 32'd1);
    wait_phase(3'd6);
    check("walk_lamp", {31'd0, walk}, 32'd1);
    run_len(3'd6, len);
    check("walk_len", len, 11);
    check("walk_to_green", {29'd0, ph}, 32'd1);
    check("ped_cleared", {31'd0, pw}, 32'd0);

    // Request coinciding with the edge that enters WALK is absorbed.
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    wait_phase(3'd0);
    @(negedge clk);
    @(negedge clk);
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    check("walk_entered", {29'd0, ph}, 32'd6);
    check("ped_absorbed", {31'd0, pw}, 32'd0);
    run_len(3'd6, len);
    check("walk_len2", len, 11);
    check("ped_after_walk", {31'd0, pw}, 32'd0);
    wait_phase(3'd0);
    run_len(3'd0, len);
    check("red_a_len2", len, 3);
    check("no_second_walk", {29'd0, ph}, 32'd1);

    // Flash override in EW_GREEN.
    wait_phase(3'd4);
    repeat (10) @(negedge clk);
    flash = 1'b1;
    @(negedge clk);
    check("flash_enter", {29'd0, ph}, 32'd7);
    for (int i = 0; i < 12; i++) begin
      logic [2:0] e;
      e = ((i / 3) % 2 == 0) ? 3'b010 : 3'b000;
      check($sformatf("flash_ns%0d", i), {29'd0, ns}, {29'd0, e});
      check($sformatf("flash_ew%0d", i), {29'd0, ew}, {29'd0, e});
      @(negedge clk);
    end
    flash = 1'b0;
    @(negedge clk);
    check("flash_exit", {29'd0, ph}, 32'd0);
    check("flash_exit_load", {31'd0, tif.load}, 32'd1);
    run_len(3'd0, len);
    check("red_a_after_flash", len, 3);
    check("green_after_flash", {29'd0, ph}, 32'd1);

    // Flash rising on the NS_YELLOW phase-end cycle.
    wait_phase(3'd2);
    repeat (5) @(negedge clk);
    check("yellow_last", {29'd0, ph}, 32'd2);
    flash = 1'b1;
    @(negedge clk);
    check("flash_wins", {29'd0, ph}, 32'd7);
    flash = 1'b0;
    @(negedge clk);
    check("flash_off", {29'd0, ph}, 32'd0);

    // Asynchronous reset in the middle of EW_GREEN.
    wait_phase(3'd4);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_phase", {29'd0, ph}, 32'd0);
    check("rst_load", {31'd0, tif.load}, 32'd1);
    check("rst_ns", {29'd0, ns}, 32'd4);
    check("rst_ew", {29'd0, ew}, 32'd4);
    check("rst_walk", {31'd0, walk}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_len(3'd0, len);
    check("rst_red_a_len", len, 3);

    check("green63_len", g2_len, 64);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
